// File: rtl/div_stall_unit_pkg.sv
// rtl/div_stall_unit_pkg.sv - shared constants for the EX-stage divider and its HI/LO write path
package div_stall_unit_pkg;

  localparam logic [1:0] DIV_IDLE = 2'b00;
  localparam logic [1:0] DIV_BUSY = 2'b01;
  localparam logic [1:0] DIV_DONE = 2'b10;

  localparam logic [1:0] HILO_WE_NONE = 2'b00;
  localparam logic [1:0] HILO_WE_LO   = 2'b01;
  localparam logic [1:0] HILO_WE_HI   = 2'b10;
  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional two's-complement negation (magnitude capture and result sign fix-up)
module div_sign_fix
  import div_stall_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] out
);

  assign out = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/div_stall_unit.sv
// rtl/div_stall_unit.sv - iterative radix-2 DIV/DIVU unit with hazard stall request and HI/LO result
// Optional macro DIV_EARLY_OUT_EN: finish in one cycle when |a| < |b|.
module div_stall_unit
  import div_stall_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 annul,
  output logic                 stall_div,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] divisor;
  logic             quo_neg;
  logic             rem_neg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             last_iter;

  assign a_neg = signed_div & a[WIDTH-1];
  assign b_neg = signed_div & b[WIDTH-1];

  div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.value(a), .negate(a_neg), .out(a_mag));
  div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.value(b), .negate(b_neg), .out(b_mag));

  // Restoring step: quo doubles as the dividend shift register, feeding its MSB into the remainder.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, divisor};

  always_comb begin
    rem_next = rem_shift[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], 1'b0};
    if (!rem_diff[WIDTH]) begin
      rem_next = rem_diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (.value(quo_next), .negate(quo_neg), .out(quo_fix));
  div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (.value(rem_next), .negate(rem_neg), .out(rem_fix));

  assign last_iter = (count == CW'(WIDTH - 1));

  // Low in DONE so the owning instruction leaves EX in the same cycle the result is written.
  assign stall_div = ((state == DIV_IDLE) & start & ~annul) | (state == DIV_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= DIV_IDLE;
      count   <= '0;
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      ready <= 1'b0;
      if (annul) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          DIV_IDLE: begin
            if (start) begin
              quo_neg <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg <= a_neg;
              count   <= '0;
              if (b == '0) begin
                state  <= DIV_DONE;
                ready  <= 1'b1;
                result <= {a, WIDTH'(DIV_ZERO_QUOTIENT)};
              end
`ifdef DIV_EARLY_OUT_EN
              else if (a_mag < b_mag) begin
                state  <= DIV_DONE;
                ready  <= 1'b1;
                result <= {a, {WIDTH{1'b0}}};
              end
`endif
              else begin
                state   <= DIV_BUSY;
                quo     <= a_mag;
                divisor <= b_mag;
                rem     <= '0;
              end
            end
          end
          DIV_BUSY: begin
            quo   <= quo_next;
            rem   <= rem_next;
            count <= count + CW'(1);
            if (last_iter) begin
              state  <= DIV_DONE;
              ready  <= 1'b1;
              result <= {rem_fix, quo_fix};
            end
          end
          default: state <= DIV_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/div_stall_unit.md
Name: div_stall_unit

Overview:
- Iterative 32-bit radix-2 integer divider for the EX stage. It serves DIV and DIVU and writes its result to HI/LO.
- It issues the stall request that the hazard unit ORs into stallF/stallD/flushE. It is the producer side of the stall interface that the hazard unit consumes.
- It delivers {remainder, quotient} to the HI/LO write path with a one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  DIV/DIVU present in EX; sampled only in IDLE.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  input  WIDTH  dividend (rs value after forwarding); sampled with start.
- b  input  WIDTH  divisor (rt value after forwarding); sampled with start.
- annul  input  1  exception or flush of the owning instruction; aborts the operation.
- stall_div  output  1  stall request to the hazard unit.
- ready  output  1  one-cycle pulse; result valid and to be written to HI/LO.
- result  output  2*WIDTH  {remainder (HI), quotient (LO)}.

Behaviour:
- Reset (asynchronous): state=IDLE, counter=0, ready=0, result=0, internal registers=0. stall_div=0.
- States:
  - IDLE -> BUSY when start & ~annul & b!=0.
  - IDLE -> DONE when start & ~annul & b==0.
  - BUSY -> DONE after exactly WIDTH iterations (counter 0..WIDTH-1).
  - DONE -> IDLE unconditionally.
  - Any state -> IDLE when annul=1.
- stall_div is combinational: (state==IDLE & start & ~annul) | state==BUSY.
  - It is 0 in DONE, so the instruction advances in the same cycle that ready=1.
- Latency: start high in cycle 0 gives BUSY in cycles 1..32, DONE/ready in cycle 33, and stall_div high in cycles 0..32.
- Capture at start:
  - |a| and |b| when signed_div=1, raw values otherwise.
  - Quotient sign = a[31]^b[31]; remainder sign = a[31]. Both signs are forced to 0 when unsigned.
- Iteration: restoring shift-subtract, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits.
- Fix-up on entering DONE: conditional two's-complement negation of quotient and remainder by their captured signs, then registered into result.
- result holds its value until the next DONE. An annul does not change result.
- Divide by zero: quotient = all ones, remainder = a (unmodified, not sign-corrected). Reached in 1 cycle: start in cycle 0, ready in cycle 1.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. Magnitude arithmetic produces this naturally, with no special case.
- Simultaneous events:
  - start while BUSY or DONE is ignored.
  - annul with start in IDLE: annul wins, no state change, stall_div=0.
  - annul in BUSY: next state IDLE, no ready pulse, stall_div drops in the next cycle.
- Reset mid-operation: immediate return to IDLE; ready=0; result=0.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE with start & ~annul & b!=0 & |a| < |b| (captured magnitudes), go directly to DONE with quotient=0 and remainder=a. Latency is then 1 cycle and stall_div is high only in cycle 0.
- Undefined: every nonzero-divisor operation takes the full WIDTH iterations.

Decomposition:
- Shared package, constants only:
  - state encoding DIV_IDLE/DIV_BUSY/DIV_DONE (2 bits);
  - hilo_we encodings 2'b00 none, 2'b01 LO, 2'b10 HI, 2'b11 both;
  - DIV_ZERO_QUOTIENT = all ones.
- One sub-module, div_sign_fix: combinational magnitude/negation helper, instantiated for operand capture and for result fix-up.

Test Plan:
- Unsigned 100/7 (signed_div=0): stall_div high in cycles 0..32, ready in cycle 33, result = {32'd2, 32'd14}.
- Signed -7/2, a=0xFFFFFFF9, b=2: result = {0xFFFFFFFF, 0xFFFFFFFD}, i.e. rem -1, quot -3.
- Divide by zero, a=0x12345678, b=0: ready in cycle 1, result = {0x12345678, 0xFFFFFFFF}.
- Overflow 0x80000000 / 0xFFFFFFFF signed: result = {0, 0x80000000}.
- annul in cycle 10 of a 100/7 run: state IDLE in cycle 11, stall_div=0 in cycle 11, no ready pulse, result keeps its prior value.
  - A second start 1000/10 then yields {0, 100} in 33 cycles.
- rst asserted mid-BUSY: outputs zero immediately without waiting for a clock edge. With DIV_EARLY_OUT_EN, 3/9 unsigned gives ready in cycle 1 with result = {3, 0}.
